// File: rtl/key_event_gen.sv
// key_event_gen
//   Converts a clean, debounced key level into single-cycle event pulses
//   for the front-panel setpoint/menu logic. One instance per key.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   key_in        debounced key level, already synchronous to clk
//   press_pulse   one-cycle pulse on each press
//   release_pulse one-cycle pulse on each release
//   short_pulse   one-cycle pulse on a release before long_pulse fired
//   long_pulse    one-cycle pulse once the press reaches LONG_CYCLES
//   repeat_pulse  one-cycle pulse every REPEAT_CYCLES after long_pulse
//   key_held      registered level, high while in PRESS or REPEAT
module key_event_gen #(
    parameter logic KEY_ACTIVE    = 1'b1,
    parameter int   LONG_CYCLES   = 500,
    parameter int   REPEAT_CYCLES = 100,
    parameter int   CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PRESS  = 2'b01,
        REPEAT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             p;

    logic press_d, release_d, short_d, long_d, repeat_d, held_d;

    assign p = (key_in == KEY_ACTIVE);

    // State register; outputs are registered alongside so every pulse
    // appears in the cycle after the edge that caused it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            short_pulse   <= short_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
            key_held      <= held_d;
        end
    end

    // Next-state and counter. Release is tested first so it wins over a
    // coincident terminal count.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (p) state_d = PRESS;
            end
            PRESS: begin
                if (!p) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!p) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode, evaluated against the current state and sample.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state)
            IDLE: press_d = p;
            PRESS: begin
                release_d = !p;
                short_d   = !p;
                long_d    = p && (cnt == LONG_LAST);
            end
            REPEAT: begin
                release_d = !p;
                repeat_d  = p && (cnt == REPEAT_LAST);
            end
            default: ;
        endcase
        held_d = (state_d == PRESS) || (state_d == REPEAT);
    end

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic key1, key0;

    logic pr1, rl1, sh1, lg1, rp1, hd1;
    logic pr0, rl0, sh0, lg0, rp0, hd0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    key_event_gen #(
        .KEY_ACTIVE   (1'b1),
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (16)
    ) dut_hi (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key1),
        .press_pulse  (pr1),
        .release_pulse(rl1),
        .short_pulse  (sh1),
        .long_pulse   (lg1),
        .repeat_pulse (rp1),
        .key_held     (hd1)
    );

    key_event_gen #(
        .KEY_ACTIVE   (1'b0),
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (16)
    ) dut_lo (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key0),
        .press_pulse  (pr0),
        .release_pulse(rl0),
        .short_pulse  (sh0),
        .long_pulse   (lg0),
        .repeat_pulse (rp0),
        .key_held     (hd0)
    );

    // Vector order: {press, release, short, long, repeat, held}
    task automatic chk(input string tag, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        key1  = 1'b0;
        key0  = 1'b1;
        #1;
        chk("rst_hi_t0", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);
        chk("rst_lo_t0", {pr0, rl0, sh0, lg0, rp0, hd0}, 6'b000000);

        // Reset hold with key toggling
        for (int i = 0; i < 4; i++) begin
            key1 = ~key1;
            tick();
            chk("rst_hold", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);
        end

        // Release reset with key pressed: first edge is N; short press of 3 edges
        key1  = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("short_N", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b100001);
        chk("lo_idle", {pr0, rl0, sh0, lg0, rp0, hd0}, 6'b000000);
        tick();
        chk("short_N1", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000001);
        tick();
        chk("short_N2", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000001);
        key1 = 1'b0;
        tick();
        chk("short_N3", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b011000);
        tick();
        chk("short_N4", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);

        // Long hold for 20 cycles: long at N+8, repeat at N+12, N+16, release at N+20
        key1 = 1'b1;
        tick();
        chk("long_N", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b100001);
        for (int i = 1; i < 20; i++) begin
            logic l, r;
            l = (i == 8);
            r = (i == 12) || (i == 16);
            tick();
            chk($sformatf("long_N%0d", i), {pr1, rl1, sh1, lg1, rp1, hd1},
                {1'b0, 1'b0, 1'b0, l, r, 1'b1});
        end
        key1 = 1'b0;
        tick();
        chk("long_rel_N20", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b010000);
        tick();
        chk("long_idle", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);

        // Boundary: first released sample at N+8 beats the long terminal count
        key1 = 1'b1;
        tick();
        chk("bnd_N", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b100001);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("bnd_N%0d", i), {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000001);
        end
        key1 = 1'b0;
        tick();
        chk("bnd_N8", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b011000);
        tick();
        chk("bnd_N9", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);

        // Reset mid-operation in REPEAT at N+10
        key1 = 1'b1;
        tick();
        chk("mid_N", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b100001);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("mid_N%0d", i), {pr1, rl1, sh1, lg1, rp1, hd1},
                {3'b000, (i == 8), 1'b0, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);
        key1 = 1'b0;
        tick();
        chk("mid_rst_rel", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_after", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);
        end

        // Active-low instance: key low for 2 edges, then high
        key0 = 1'b0;
        tick();
        chk("lo_N", {pr0, rl0, sh0, lg0, rp0, hd0}, 6'b100001);
        tick();
        chk("lo_N1", {pr0, rl0, sh0, lg0, rp0, hd0}, 6'b000001);
        key0 = 1'b1;
        tick();
        chk("lo_N2", {pr0, rl0, sh0, lg0, rp0, hd0}, 6'b011000);
        tick();
        chk("lo_N3", {pr0, rl0, sh0, lg0, rp0, hd0}, 6'b000000);
        chk("hi_quiet", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b000000);

        // Re-press on the edge right after a release edge
        key1 = 1'b1;
        tick();
        chk("bb_N", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b100001);
        key1 = 1'b0;
        tick();
        chk("bb_rel", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b011000);
        key1 = 1'b1;
        tick();
        chk("bb_repress", {pr1, rl1, sh1, lg1, rp1, hd1}, 6'b100001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
